// File: rtl/y_ctrl_pkg.sv
// Shared types and constants for the multicycle RISC-V control unit.
// The FSM states, instruction classes, opcodes and ALU operation codes live here.
package y_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_JAL,
    CLS_ILL
  } iclass_e;

  localparam logic [6:0] OPC_R    = 7'h33;
  localparam logic [6:0] OPC_ADDI = 7'h13;
  localparam logic [6:0] OPC_LW   = 7'h03;
  localparam logic [6:0] OPC_SW   = 7'h23;
  localparam logic [6:0] OPC_BEQ  = 7'h63;
  localparam logic [6:0] OPC_JAL  = 7'h6F;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic [2:0] F3_OR = 3'b110;

endpackage

// File: rtl/y_ctrl_decode.sv
// Combinational instruction classifier: maps the latched opcode and funct3
// to an instruction class and the ALU operation used during EXEC.
module y_ctrl_decode
  import y_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  output iclass_e    iclass_o,
  output logic [2:0] aluOp_o
);

  always_comb begin
    iclass_o = CLS_ILL;
    aluOp_o  = ALU_ADD;
    case (opcode_i)
      OPC_R: begin
        iclass_o = CLS_R;
        if (funct3_i == F3_OR) aluOp_o = ALU_OR;
      end
      OPC_ADDI: iclass_o = CLS_ADDI;
      OPC_LW:   iclass_o = CLS_LW;
      OPC_SW:   iclass_o = CLS_SW;
      OPC_BEQ: begin
        iclass_o = CLS_BEQ;
        aluOp_o  = ALU_SUB;
      end
      OPC_JAL:  iclass_o = CLS_JAL;
      default:  ;
    endcase
  end

endmodule

// File: rtl/y_mc_ctrl.sv
// Multicycle control unit: latches the fetched instruction into IR and steps
// FETCH/DECODE/EXEC/MEM/WB, driving Moore-style datapath controls per state.
module y_mc_ctrl
  import y_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic             INT,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             pc_int,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Mem2Reg,
  output logic             isbranch,
  output logic             isjump,
  output logic [2:0]       op,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [31:0]      ir_q;
  logic [CNT_W-1:0] retired_q;
  iclass_e          iclass;
  logic [2:0]       aluOp;
  logic             retire;
  logic             unusedBits;

  // Branch resolution is done in yPC, so the zero flag and most IR fields never reach the FSM.
  assign unusedBits = ^{zero, ir_q[31:15], ir_q[11:7]};

  y_ctrl_decode u_decode (
    .opcode_i (ir_q[6:0]),
    .funct3_i (ir_q[14:12]),
    .iclass_o (iclass),
    .aluOp_o  (aluOp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           ir_q <= '0;
    else if (state_q == S_FETCH && !INT) ir_q <= ins;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retired_q <= '0;
    else if (retire) retired_q <= retired_q + CNT_W'(1);
  end

  // retire marks the final state of each instruction, the same cycle PCWrite is raised.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (!INT) state_d = S_DECODE;
      S_DECODE: state_d = (iclass == CLS_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (iclass)
          CLS_BEQ: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          CLS_LW, CLS_SW: state_d = S_MEM;
          default:        state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (iclass == CLS_LW) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
          retire  = (iclass == CLS_SW);
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    pc_int   = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Mem2Reg  = 1'b0;
    isbranch = 1'b0;
    isjump   = 1'b0;
    op       = ALU_ADD;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (INT) begin
          PCWrite = 1'b1;
          pc_int  = 1'b1;
        end else begin
          IRWrite = 1'b1;
        end
      end
      S_EXEC: begin
        op = aluOp;
        if (iclass == CLS_R) ALUSrc = 1'b0;
        if (iclass == CLS_BEQ) begin
          ALUSrc   = 1'b0;
          isbranch = 1'b1;
          PCWrite  = 1'b1;
        end
      end
      S_MEM: begin
        if (iclass == CLS_LW) MemRead = 1'b1;
        if (iclass == CLS_SW) begin
          MemWrite = 1'b1;
          PCWrite  = 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        if (iclass == CLS_LW) begin
          MemRead = 1'b1;
          Mem2Reg = 1'b1;
        end
        if (iclass == CLS_JAL) isjump = 1'b1;
      end
      S_TRAP: begin
        ALUSrc  = 1'b0;
        op      = 3'b000;
        illegal = 1'b1;
      end
      default: ;
    endcase
    // Reset silences every control at once so an aborted instruction cannot leak a write.
    if (rst) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      pc_int   = 1'b0;
      RegWrite = 1'b0;
      ALUSrc   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Mem2Reg  = 1'b0;
      isbranch = 1'b0;
      isjump   = 1'b0;
      op       = 3'b000;
      illegal  = 1'b0;
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_y_mc_ctrl.sv
// Directed bench for y_mc_ctrl: one task per scenario, hand-computed control
// vectors per cycle; a second instance with a 2-bit counter checks wrap-around.
module tb_y_mc_ctrl;

  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_LW   = 32'h0000_A103;
  localparam logic [31:0] I_SW   = 32'h0020_A023;
  localparam logic [31:0] I_BEQ  = 32'h0020_8463;
  localparam logic [31:0] I_OR   = 32'h0020_E1B3;
  localparam logic [31:0] I_ADD  = 32'h0020_81B3;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_BAD  = 32'h0000_007F;
  localparam logic [31:0] JUNK   = 32'hFFFF_FFFF;

  // Vector order: IRWrite PCWrite pc_int RegWrite ALUSrc MemRead MemWrite Mem2Reg isbranch isjump op[2:0] illegal
  localparam logic [13:0] C_ZERO  = 14'b0_0_0_0_0_0_0_0_0_0_000_0;
  localparam logic [13:0] C_FETCH = 14'b1_0_0_0_1_0_0_0_0_0_010_0;
  localparam logic [13:0] C_FINT  = 14'b0_1_1_0_1_0_0_0_0_0_010_0;
  localparam logic [13:0] C_IDLE  = 14'b0_0_0_0_1_0_0_0_0_0_010_0;
  localparam logic [13:0] C_RADD  = 14'b0_0_0_0_0_0_0_0_0_0_010_0;
  localparam logic [13:0] C_ROR   = 14'b0_0_0_0_0_0_0_0_0_0_001_0;
  localparam logic [13:0] C_BEQ   = 14'b0_1_0_0_0_0_0_0_1_0_110_0;
  localparam logic [13:0] C_MLW   = 14'b0_0_0_0_1_1_0_0_0_0_010_0;
  localparam logic [13:0] C_MSW   = 14'b0_1_0_0_1_0_1_0_0_0_010_0;
  localparam logic [13:0] C_WB    = 14'b0_1_0_1_1_0_0_0_0_0_010_0;
  localparam logic [13:0] C_WLW   = 14'b0_1_0_1_1_1_0_1_0_0_010_0;
  localparam logic [13:0] C_WJAL  = 14'b0_1_0_1_1_0_0_0_0_1_010_0;
  localparam logic [13:0] C_TRAP  = 14'b0_0_0_0_0_0_0_0_0_0_000_1;
  localparam logic [13:0] M_ALL   = 14'b1_1_1_1_1_1_1_1_1_1_111_1;
  localparam logic [13:0] M_TRAP  = 14'b1_1_1_1_0_1_1_1_1_1_000_1;

  logic        clk;
  logic        rst;
  logic [31:0] ins;
  logic        zero;
  logic        INT;

  logic        IRWrite, PCWrite, pc_int, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg;
  logic        isbranch, isjump, illegal;
  logic [2:0]  op;
  logic [15:0] retired;

  logic        IRWrite2, PCWrite2, pc_int2, RegWrite2, ALUSrc2, MemRead2, MemWrite2, Mem2Reg2;
  logic        isbranch2, isjump2, illegal2;
  logic [2:0]  op2;
  logic [1:0]  retired2;

  logic [13:0] ctl;
  int          total;
  int          bad;

  assign ctl = {IRWrite, PCWrite, pc_int, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg,
                isbranch, isjump, op, illegal};

  y_mc_ctrl dut (
    .clk(clk), .rst(rst), .ins(ins), .zero(zero), .INT(INT),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .pc_int(pc_int), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite), .Mem2Reg(Mem2Reg),
    .isbranch(isbranch), .isjump(isjump), .op(op), .illegal(illegal), .retired(retired)
  );

  y_mc_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .ins(ins), .zero(zero), .INT(INT),
    .IRWrite(IRWrite2), .PCWrite(PCWrite2), .pc_int(pc_int2), .RegWrite(RegWrite2),
    .ALUSrc(ALUSrc2), .MemRead(MemRead2), .MemWrite(MemWrite2), .Mem2Reg(Mem2Reg2),
    .isbranch(isbranch2), .isjump(isjump2), .op(op2), .illegal(illegal2), .retired(retired2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset held across an edge: every output must be zero, even with INT high.
  task automatic test_reset();
    @(negedge clk);
    #1;
    total++;
    if (ctl !== C_ZERO) begin
      bad++;
      $display("[TB] FAIL reset_ctl got %b want %b", ctl, C_ZERO);
    end
    total++;
    if (retired !== 16'd0 || retired2 !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_retired got %0d/%0d want 0/0", retired, retired2);
    end
    INT = 1'b1;
    #1;
    total++;
    if (ctl !== C_ZERO) begin
      bad++;
      $display("[TB] FAIL reset_int_ctl got %b want %b", ctl, C_ZERO);
    end
    @(negedge clk);
    rst = 1'b0;
    INT = 1'b0;
  endtask

  // Live ins is junk after FETCH so any decode from ins instead of IR shows up.
  task automatic test_addi();
    logic [13:0] expV [4];
    expV = '{C_FETCH, C_IDLE, C_IDLE, C_WB};
    for (int k = 0; k < 4; k++) begin
      ins  = (k == 0) ? I_ADDI : JUNK;
      INT  = 1'b0;
      zero = k[0];
      #1;
      total++;
      if (ctl !== expV[k]) begin
        bad++;
        $display("[TB] FAIL addi_cyc%0d got %b want %b", k, ctl, expV[k]);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (retired !== 16'd1) begin
      bad++;
      $display("[TB] FAIL addi_retired got %0d want 1", retired);
    end
  endtask

  task automatic test_lw_sw();
    logic [31:0] insV [9];
    logic [13:0] expV [9];
    insV = '{I_LW, JUNK, JUNK, JUNK, JUNK, I_SW, JUNK, JUNK, JUNK};
    expV = '{C_FETCH, C_IDLE, C_IDLE, C_MLW, C_WLW, C_FETCH, C_IDLE, C_IDLE, C_MSW};
    for (int k = 0; k < 9; k++) begin
      ins  = insV[k];
      INT  = 1'b0;
      zero = ~k[0];
      #1;
      total++;
      if (ctl !== expV[k]) begin
        bad++;
        $display("[TB] FAIL lwsw_cyc%0d got %b want %b", k, ctl, expV[k]);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (retired !== 16'd3) begin
      bad++;
      $display("[TB] FAIL lwsw_retired got %0d want 3", retired);
    end
  endtask

  // beq (3 cycles), or and add (4 each), jal (4) back to back.
  task automatic test_alu_branch_jump();
    logic [31:0] insV [15];
    logic [13:0] expV [15];
    insV = '{I_BEQ, JUNK, JUNK,
             I_OR,  JUNK, JUNK, JUNK,
             I_ADD, JUNK, JUNK, JUNK,
             I_JAL, JUNK, JUNK, JUNK};
    expV = '{C_FETCH, C_IDLE, C_BEQ,
             C_FETCH, C_IDLE, C_ROR,  C_WB,
             C_FETCH, C_IDLE, C_RADD, C_WB,
             C_FETCH, C_IDLE, C_IDLE, C_WJAL};
    for (int k = 0; k < 15; k++) begin
      ins  = insV[k];
      INT  = 1'b0;
      zero = 1'b1;
      #1;
      total++;
      if (ctl !== expV[k]) begin
        bad++;
        $display("[TB] FAIL alu_cyc%0d got %b want %b", k, ctl, expV[k]);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (retired !== 16'd7) begin
      bad++;
      $display("[TB] FAIL alu_retired got %0d want 7", retired);
    end
  endtask

  // INT honoured twice in FETCH, then ignored while the addi is in flight.
  task automatic test_int();
    logic [31:0] insV [6];
    logic        intV [6];
    logic [13:0] expV [6];
    insV = '{I_BAD, I_BAD, I_ADDI, JUNK, JUNK, JUNK};
    intV = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    expV = '{C_FINT, C_FINT, C_FETCH, C_IDLE, C_IDLE, C_WB};
    for (int k = 0; k < 6; k++) begin
      ins  = insV[k];
      INT  = intV[k];
      zero = 1'b0;
      #1;
      total++;
      if (ctl !== expV[k]) begin
        bad++;
        $display("[TB] FAIL int_cyc%0d got %b want %b", k, ctl, expV[k]);
      end
      @(negedge clk);
    end
    INT = 1'b0;
    #1;
    total++;
    if (retired !== 16'd8) begin
      bad++;
      $display("[TB] FAIL int_retired got %0d want 8", retired);
    end
  endtask

  task automatic test_trap();
    logic [31:0] insV [7];
    logic [13:0] expV [7];
    logic [13:0] mskV [7];
    insV = '{I_BAD, JUNK, I_ADDI, I_ADDI, JUNK, I_ADDI, JUNK};
    expV = '{C_FETCH, C_IDLE, C_TRAP, C_TRAP, C_TRAP, C_TRAP, C_TRAP};
    mskV = '{M_ALL, M_ALL, M_TRAP, M_TRAP, M_TRAP, M_TRAP, M_TRAP};
    for (int k = 0; k < 7; k++) begin
      ins  = insV[k];
      INT  = (k == 4);
      zero = 1'b0;
      #1;
      total++;
      if ((ctl & mskV[k]) !== expV[k]) begin
        bad++;
        $display("[TB] FAIL trap_cyc%0d got %b want %b", k, ctl & mskV[k], expV[k]);
      end
      @(negedge clk);
    end
    INT = 1'b0;
    #1;
    total++;
    if (retired !== 16'd8) begin
      bad++;
      $display("[TB] FAIL trap_retired got %0d want 8", retired);
    end
  endtask

  // Reset out of TRAP, run an addi, then abort a lw in its MEM cycle.
  task automatic test_reset_abort();
    logic [31:0] insV [7];
    logic [13:0] expV [7];
    rst = 1'b1;
    #1;
    total++;
    if (ctl !== C_ZERO || retired !== 16'd0) begin
      bad++;
      $display("[TB] FAIL trap_clear got %b/%0d want %b/0", ctl, retired, C_ZERO);
    end
    @(negedge clk);
    rst  = 1'b0;
    insV = '{I_ADDI, JUNK, JUNK, JUNK, I_LW, JUNK, JUNK};
    expV = '{C_FETCH, C_IDLE, C_IDLE, C_WB, C_FETCH, C_IDLE, C_IDLE};
    for (int k = 0; k < 7; k++) begin
      ins  = insV[k];
      INT  = 1'b0;
      zero = 1'b0;
      #1;
      total++;
      if (ctl !== expV[k]) begin
        bad++;
        $display("[TB] FAIL abort_cyc%0d got %b want %b", k, ctl, expV[k]);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (retired !== 16'd1) begin
      bad++;
      $display("[TB] FAIL abort_pre_retired got %0d want 1", retired);
    end
    rst = 1'b1;
    #1;
    total++;
    if (ctl !== C_ZERO || retired !== 16'd0) begin
      bad++;
      $display("[TB] FAIL abort_rst got %b/%0d want %b/0", ctl, retired, C_ZERO);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Four addis after reset: 16-bit counter reads 4, 2-bit counter wraps to 0.
  task automatic test_wrap();
    logic [13:0] expV [4];
    expV = '{C_FETCH, C_IDLE, C_IDLE, C_WB};
    for (int k = 0; k < 16; k++) begin
      ins  = ((k % 4) == 0) ? I_ADDI : JUNK;
      INT  = 1'b0;
      zero = k[1];
      #1;
      total++;
      if (ctl !== expV[k % 4]) begin
        bad++;
        $display("[TB] FAIL wrap_cyc%0d got %b want %b", k, ctl, expV[k % 4]);
      end
      if (k == 12) begin
        total++;
        if (retired2 !== 2'd3) begin
          bad++;
          $display("[TB] FAIL wrap_pre got %0d want 3", retired2);
        end
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (retired !== 16'd4) begin
      bad++;
      $display("[TB] FAIL wrap_retired16 got %0d want 4", retired);
    end
    total++;
    if (retired2 !== 2'd0) begin
      bad++;
      $display("[TB] FAIL wrap_retired2 got %0d want 0", retired2);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    INT   = 1'b0;
    zero  = 1'b0;
    ins   = I_ADDI;
    test_reset();
    test_addi();
    test_lw_sw();
    test_alu_branch_jump();
    test_int();
    test_trap();
    test_reset_abort();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
